// File: rtl/proj_pkg.sv
// Shared constants and types for the projection hasher.
//   HASHER_DATA_LEN          width of one input data word
//   INDICE_LEN               width of element indices and counts
//   HASHER_SORTER_SIGNATURE  width of the signature handed to the sorter
//   HASH_MULT / HASH_SEED    multiplicative hash constant and default seed
//   hasher_state_e           hasher control FSM states
package proj_pkg;

    localparam int unsigned HASHER_DATA_LEN         = 32;
    localparam int unsigned INDICE_LEN              = 8;
    localparam int unsigned HASHER_SORTER_SIGNATURE = 32;

    localparam logic [31:0] HASH_MULT = 32'h9E3779B1;
    localparam logic [31:0] HASH_SEED = 32'h0000_0000;

    // Three hash stages plus the sorter's own input register.
    localparam logic [1:0] DRAIN_LAST = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccept,
        StDrain,
        StDone
    } hasher_state_e;

endpackage

// File: rtl/proj_hash_pipe.sv
// Three-stage hash pipeline feeding the sorter.
//   s1 = data ^ seed; s2 = s1 * HASH_MULT (truncated); s3 = s2 ^ (s2 >> SIGNATURE_LEN/2)
// An all-ones signature marks a bubble, so a real hash of all-ones is remapped to all-ones - 1.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears every stage to a bubble)
//   in_valid       a word enters the pipe this cycle
//   in_data        data word
//   in_index       index travelling alongside the word
//   seed           hash seed
//   out_signature  signature, all-ones for a bubble
//   out_index      index, 0 for a bubble
module proj_hash_pipe
    import proj_pkg::*;
#(
    parameter int unsigned DATA_LEN      = HASHER_DATA_LEN,
    parameter int unsigned INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int unsigned SIGNATURE_LEN = HASHER_SORTER_SIGNATURE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_LEN-1:0]      in_data,
    input  logic [INDICE_LEN-1:0]    in_index,
    input  logic [DATA_LEN-1:0]      seed,
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0]    out_index
);

    localparam logic [SIGNATURE_LEN-1:0] SigBubble   = '1;
    localparam logic [SIGNATURE_LEN-1:0] SigReserved = {{(SIGNATURE_LEN-1){1'b1}}, 1'b0};
    localparam logic [SIGNATURE_LEN-1:0] Mult        = SIGNATURE_LEN'(HASH_MULT);

    logic                     s1_vld_q, s2_vld_q;
    logic [DATA_LEN-1:0]      s1_q;
    logic [SIGNATURE_LEN-1:0] s2_q, s2_d, s3, sig_d, sig_q;
    logic [INDICE_LEN-1:0]    s1_idx_q, s2_idx_q, idx_q;

    always_comb begin
        s2_d = SIGNATURE_LEN'(s1_q) * Mult;
        s3   = s2_q ^ (s2_q >> (SIGNATURE_LEN / 2));
        if (!s2_vld_q) begin
            sig_d = SigBubble;
        end else if (s3 == SigBubble) begin
            sig_d = SigReserved;
        end else begin
            sig_d = s3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s1_idx_q <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
            s2_idx_q <= '0;
            sig_q    <= SigBubble;
            idx_q    <= '0;
        end else begin
            s1_vld_q <= in_valid;
            s1_q     <= in_data ^ seed;
            s1_idx_q <= in_index;
            s2_vld_q <= s1_vld_q;
            s2_q     <= s2_d;
            s2_idx_q <= s1_idx_q;
            sig_q    <= sig_d;
            idx_q    <= s2_vld_q ? s2_idx_q : '0;
        end
    end

    assign out_signature = sig_q;
    assign out_index     = idx_q;

endmodule

// File: rtl/proj_hasher.sv
// Projection hasher: accepts a set of in_count words, hashes each with its index and streams
// (signature, index) pairs to a downstream sorter, then pulses out_done once the sorter is final.
// Optional macro PROJ_HASHER_SEED_EN adds port in_seed, latched on an accepted in_start.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_start          begin a new set (IDLE only), in_count sampled with it
//   in_data/in_valid  word stream, accepted when in_valid && out_ready
//   in_seed           hash seed (PROJ_HASHER_SEED_EN only)
//   out_ready         high only while accepting words
//   out_signature     signature to the sorter, all-ones = bubble
//   out_index         index paired with out_signature
//   out_sorter_rst_n  active-low sorter clear, ANDed with rst_n
//   out_busy          high outside IDLE
//   out_done          one-cycle pulse, sorter output final
module proj_hasher
    import proj_pkg::*;
#(
    parameter int unsigned DATA_LEN      = HASHER_DATA_LEN,
    parameter int unsigned INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int unsigned SIGNATURE_LEN = HASHER_SORTER_SIGNATURE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_start,
    input  logic [INDICE_LEN-1:0]    in_count,
    input  logic [DATA_LEN-1:0]      in_data,
`ifdef PROJ_HASHER_SEED_EN
    input  logic [DATA_LEN-1:0]      in_seed,
`endif
    input  logic                     in_valid,
    output logic                     out_ready,
    output logic [SIGNATURE_LEN-1:0] out_signature,
    output logic [INDICE_LEN-1:0]    out_index,
    output logic                     out_sorter_rst_n,
    output logic                     out_busy,
    output logic                     out_done
);

    hasher_state_e           state_q;
    logic [INDICE_LEN-1:0]   count_q, index_q;
    logic [1:0]              drain_q;
    logic                    ready_q, busy_q, done_q, clear_q;
    logic                    accept, last_word;
    logic [DATA_LEN-1:0]     seed;

`ifdef PROJ_HASHER_SEED_EN
    logic [DATA_LEN-1:0] seed_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_q <= '0;
        end else if (state_q == StIdle && in_start) begin
            seed_q <= in_seed;
        end
    end

    assign seed = seed_q;
`else
    assign seed = DATA_LEN'(HASH_SEED);
`endif

    // ready_q mirrors state_q == StAccept, so it doubles as the accept qualifier.
    assign accept    = ready_q && in_valid;
    assign last_word = ({1'b0, index_q} + (INDICE_LEN + 1)'(1)) == {1'b0, count_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            index_q <= '0;
            drain_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_start) begin
                        state_q <= StClear;
                        count_q <= in_count;
                        index_q <= '0;
                        clear_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    if (count_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StAccept;
                        ready_q <= 1'b1;
                    end
                end
                StAccept: begin
                    if (accept && last_word) begin
                        index_q <= index_q + INDICE_LEN'(1);
                        state_q <= StDrain;
                        drain_q <= '0;
                    end else begin
                        if (accept) begin
                            index_q <= index_q + INDICE_LEN'(1);
                        end
                        ready_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    proj_hash_pipe #(
        .DATA_LEN      (DATA_LEN),
        .INDICE_LEN    (INDICE_LEN),
        .SIGNATURE_LEN (SIGNATURE_LEN)
    ) u_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (accept),
        .in_data       (in_data),
        .in_index      (index_q),
        .seed          (seed),
        .out_signature (out_signature),
        .out_index     (out_index)
    );

    assign out_ready        = ready_q;
    assign out_busy         = busy_q;
    assign out_done         = done_q;
    assign out_sorter_rst_n = rst_n & ~clear_q;

endmodule

// File: tb/tb_proj_hasher.sv
// Directed self-checking bench for proj_hasher (SIGNATURE_LEN=32, seed 0).
module tb_proj_hasher;
    import proj_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_start;
    logic [7:0]  in_count;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] in_seed;
    logic        out_ready;
    logic [31:0] out_signature;
    logic [7:0]  out_index;
    logic        out_sorter_rst_n;
    logic        out_busy;
    logic        out_done;

    proj_hasher u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_start         (in_start),
        .in_count         (in_count),
        .in_data          (in_data),
`ifdef PROJ_HASHER_SEED_EN
        .in_seed          (in_seed),
`endif
        .in_valid         (in_valid),
        .out_ready        (out_ready),
        .out_signature    (out_signature),
        .out_index        (out_index),
        .out_sorter_rst_n (out_sorter_rst_n),
        .out_busy         (out_busy),
        .out_done         (out_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log of non-bubble outputs and done pulses, sampled mid-cycle.
    logic [31:0] rec_sig[$];
    logic [7:0]  rec_idx[$];
    int          rec_cyc[$];
    int          done_n = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_signature !== 32'hFFFF_FFFF || out_index !== 8'd0) begin
                rec_sig.push_back(out_signature);
                rec_idx.push_back(out_index);
                rec_cyc.push_back(cyc);
            end
            if (out_done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rec_sig.delete();
        rec_idx.delete();
        rec_cyc.delete();
        done_n = 0;
    endtask

    task automatic start_set(input logic [7:0] n);
        in_start = 1'b1;
        in_count = n;
        tick();
        in_start = 1'b0;
        tick();
    endtask

    task automatic feed(input logic [31:0] d, output int acc_edge);
        in_valid = 1'b1;
        in_data  = d;
        acc_edge = cyc + 1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_n == 0 && k < 40) begin
            tick();
            k++;
        end
        if (done_n == 0) check_eq("done_timeout", 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_rec(input string tag, input int i, input logic [31:0] sig,
                             input logic [7:0] idx, input int at);
        if (rec_sig.size() > i) begin
            check_eq({tag, "_sig"}, rec_sig[i], sig);
            check_eq({tag, "_idx"}, 32'(rec_idx[i]), 32'(idx));
            check_eq({tag, "_cyc"}, rec_cyc[i], at);
        end else begin
            check_eq({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    // Inverse of an odd number mod 2^32 by Newton iteration.
    function automatic logic [31:0] mul_inv(input logic [31:0] a);
        logic [31:0] x = a;
        for (int i = 0; i < 5; i++) x = x * (32'd2 - a * x);
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    logic [31:0] exp_c[4];
    int          acc;
    int          acc_c[4];
    logic [31:0] pre_ones;

    initial begin
        exp_c[0] = 32'h9E37_E786;
        exp_c[1] = 32'h3C6E_CF0C;
        exp_c[2] = 32'hDAA6_B7B5;
        exp_c[3] = 32'h78DD_9E19;
        // s2 = FFFF0000 gives s3 = all-ones.
        pre_ones = 32'hFFFF_0000 * mul_inv(32'h9E37_79B1);

        rst_n = 1'b0; in_start = 1'b0; in_count = '0; in_data = '0;
        in_valid = 1'b0; in_seed = '0;
        tick();
        tick();
        check_eq("rst_ready", 32'(out_ready), 32'd0);
        check_eq("rst_busy", 32'(out_busy), 32'd0);
        check_eq("rst_done", 32'(out_done), 32'd0);
        check_eq("rst_sig", out_signature, 32'hFFFF_FFFF);
        check_eq("rst_idx", 32'(out_index), 32'd0);
        check_eq("rst_sorter", 32'(out_sorter_rst_n), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_sorter", 32'(out_sorter_rst_n), 32'd1);

        // Single word, data 1.
        clear_log();
        in_start = 1'b1; in_count = 8'd1;
        tick();
        in_start = 1'b0;
        check_eq("a_clear_busy", 32'(out_busy), 32'd1);
        check_eq("a_clear_sorter", 32'(out_sorter_rst_n), 32'd0);
        check_eq("a_clear_ready", 32'(out_ready), 32'd0);
        tick();
        check_eq("a_accept_ready", 32'(out_ready), 32'd1);
        check_eq("a_accept_sorter", 32'(out_sorter_rst_n), 32'd1);
        feed(32'h1, acc);
        check_eq("a_ready_drop", 32'(out_ready), 32'd0);
        wait_done();
        check_eq("a_nrec", rec_sig.size(), 32'd1);
        check_rec("a", 0, 32'h9E37_E786, 8'd0, acc + 2);
        check_eq("a_done_cyc", done_cyc, acc + 4);
        check_eq("a_done_n", done_n, 32'd1);
        check_eq("a_busy_end", 32'(out_busy), 32'd0);

        // Empty set.
        clear_log();
        in_start = 1'b1; in_count = 8'd0;
        tick();
        in_start = 1'b0;
        check_eq("b_clear_sorter", 32'(out_sorter_rst_n), 32'd0);
        tick();
        check_eq("b_done", 32'(out_done), 32'd1);
        check_eq("b_ready", 32'(out_ready), 32'd0);
        tick();
        check_eq("b_done_off", 32'(out_done), 32'd0);
        check_eq("b_busy_off", 32'(out_busy), 32'd0);
        check_eq("b_nrec", rec_sig.size(), 32'd0);
        check_eq("b_done_n", done_n, 32'd1);

        // Four words with in_valid low every other cycle.
        clear_log();
        start_set(8'd4);
        for (int i = 0; i < 4; i++) begin
            feed(32'(i + 1), acc_c[i]);
            if (i < 3) begin
                check_eq("c_ready_mid", 32'(out_ready), 32'd1);
                tick();
            end else begin
                check_eq("c_ready_drop", 32'(out_ready), 32'd0);
            end
        end
        wait_done();
        check_eq("c_nrec", rec_sig.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_rec("c", i, exp_c[i], 8'(i), acc_c[i] + 2);
        check_eq("c_done_n", done_n, 32'd1);

        // Hash of all-ones remapped.
        clear_log();
        start_set(8'd1);
        feed(pre_ones, acc);
        wait_done();
        check_rec("d", 0, 32'hFFFF_FFFE, 8'd0, acc + 2);

        // Reset in the middle of a set.
        clear_log();
        start_set(8'd4);
        feed(32'h5, acc);
        rst_n = 1'b0;
        tick();
        check_eq("e_busy", 32'(out_busy), 32'd0);
        check_eq("e_ready", 32'(out_ready), 32'd0);
        check_eq("e_sig", out_signature, 32'hFFFF_FFFF);
        check_eq("e_sorter", 32'(out_sorter_rst_n), 32'd0);
        rst_n = 1'b1;
        repeat (8) tick();
        check_eq("e_nrec", rec_sig.size(), 32'd0);
        check_eq("e_done_n", done_n, 32'd0);
        start_set(8'd1);
        feed(32'h2, acc);
        wait_done();
        check_rec("e_after", 0, 32'h3C6E_CF0C, 8'd0, acc + 2);
        check_eq("e_after_done_n", done_n, 32'd1);

        // in_start during DRAIN is ignored.
        clear_log();
        start_set(8'd1);
        feed(32'h3, acc);
        tick();
        in_start = 1'b1; in_count = 8'd2;
        tick();
        in_start = 1'b0;
        wait_done();
        repeat (4) tick();
        check_eq("f_done_n", done_n, 32'd1);
        check_eq("f_done_cyc", done_cyc, acc + 4);
        check_eq("f_busy", 32'(out_busy), 32'd0);
        check_eq("f_nrec", rec_sig.size(), 32'd1);
        check_rec("f", 0, 32'hDAA6_B7B5, 8'd0, acc + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
